// File: rtl/uart_rx_fifo.sv
// UART receiver with runtime baud divisor, optional parity, 1/2 stop bits and
// 3-sample majority voting, feeding a show-ahead FIFO drained by valid/ready.
module uart_rx_fifo #(
    parameter int PAYLOAD_BITS = 8,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1,
    parameter int DIV_WIDTH    = 16,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                          clk,
    input  logic                          resetn,
    input  logic                          uart_rxd,
    input  logic                          uart_rx_en,
    input  logic [DIV_WIDTH-1:0]          baud_div,
    output logic [PAYLOAD_BITS-1:0]       rx_data,
    output logic                          rx_parity_err,
    output logic                          rx_frame_err,
    output logic                          rx_valid,
    input  logic                          rx_ready,
    output logic                          rx_break,
    output logic                          rx_overrun,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int W  = PAYLOAD_BITS + 2;

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

    logic                    sync1_q, rxd_s_q;
    state_t                  state_q;
    logic [DIV_WIDTH-1:0]    cyc_q, div_q;
    logic [3:0]              bit_cnt_q;
    logic                    s0_q, s1_q;
    logic [PAYLOAD_BITS-1:0] data_q;
    logic                    par_bit_q, parity_err_q, frame_err_q, stop_zero_q;
    logic                    brk_wait_q, break_q, push_q;
    logic [W-1:0]            word_q;

    logic [DIV_WIDTH-1:0]    half, s_lo, s_hi, last;
    logic                    at_res, at_last, maj;

    assign half    = div_q >> 1;
    assign s_lo    = half - DIV_WIDTH'(1);
    assign s_hi    = half + DIV_WIDTH'(1);
    assign last    = div_q - DIV_WIDTH'(1);
    assign at_res  = (cyc_q == s_hi);
    assign at_last = (cyc_q == last);
    assign maj     = (s0_q & s1_q) | (s0_q & rxd_s_q) | (s1_q & rxd_s_q);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            sync1_q <= 1'b1;
            rxd_s_q <= 1'b1;
        end else begin
            sync1_q <= uart_rx_en ? uart_rxd : 1'b1;
            rxd_s_q <= uart_rx_en ? sync1_q : 1'b1;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q      <= S_IDLE;
            cyc_q        <= '0;
            div_q        <= '0;
            bit_cnt_q    <= '0;
            s0_q         <= 1'b1;
            s1_q         <= 1'b1;
            data_q       <= '0;
            par_bit_q    <= 1'b0;
            parity_err_q <= 1'b0;
            frame_err_q  <= 1'b0;
            stop_zero_q  <= 1'b1;
            brk_wait_q   <= 1'b0;
            break_q      <= 1'b0;
            push_q       <= 1'b0;
            word_q       <= '0;
        end else begin
            break_q <= 1'b0;
            push_q  <= 1'b0;
            if (!uart_rx_en) begin
                state_q    <= S_IDLE;
                cyc_q      <= '0;
                brk_wait_q <= 1'b0;
            end else begin
                if (state_q != S_IDLE) begin
                    if (cyc_q == s_lo) s0_q <= rxd_s_q;
                    if (cyc_q == half) s1_q <= rxd_s_q;
                    cyc_q <= at_last ? '0 : cyc_q + DIV_WIDTH'(1);
                end
                case (state_q)
                    S_IDLE: begin
                        cyc_q <= '0;
                        // After a break the line must go idle before a new start is armed.
                        if (brk_wait_q) begin
                            if (rxd_s_q) brk_wait_q <= 1'b0;
                        end else if (!rxd_s_q) begin
                            state_q      <= S_START;
                            div_q        <= baud_div;
                            par_bit_q    <= 1'b0;
                            parity_err_q <= 1'b0;
                            frame_err_q  <= 1'b0;
                            stop_zero_q  <= 1'b1;
                        end
                    end
                    S_START: begin
                        if (at_res && maj) begin
                            state_q <= S_IDLE;
                        end else if (at_last) begin
                            state_q   <= S_DATA;
                            bit_cnt_q <= '0;
                        end
                    end
                    S_DATA: begin
                        if (at_res) data_q <= {maj, data_q[PAYLOAD_BITS-1:1]};
                        if (at_last) begin
                            if (bit_cnt_q == 4'(PAYLOAD_BITS - 1)) begin
                                state_q   <= (PARITY != 0) ? S_PARITY : S_STOP;
                                bit_cnt_q <= '0;
                            end else begin
                                bit_cnt_q <= bit_cnt_q + 4'd1;
                            end
                        end
                    end
                    S_PARITY: begin
                        if (at_res) begin
                            par_bit_q    <= maj;
                            parity_err_q <= (PARITY == 1) ? ((^data_q) ^ maj) : ~((^data_q) ^ maj);
                        end
                        if (at_last) begin
                            state_q   <= S_STOP;
                            bit_cnt_q <= '0;
                        end
                    end
                    S_STOP: begin
                        if (at_res) begin
                            if (bit_cnt_q == 4'(STOP_BITS - 1)) begin
                                state_q <= S_IDLE;
                                if (data_q == '0 && !par_bit_q && stop_zero_q && !maj) begin
                                    break_q    <= 1'b1;
                                    brk_wait_q <= 1'b1;
                                end else begin
                                    push_q <= 1'b1;
                                    word_q <= {frame_err_q | ~maj, parity_err_q, data_q};
                                end
                            end else begin
                                frame_err_q <= frame_err_q | ~maj;
                                stop_zero_q <= stop_zero_q & ~maj;
                            end
                        end
                        if (at_last) bit_cnt_q <= bit_cnt_q + 4'd1;
                    end
                    default: state_q <= S_IDLE;
                endcase
            end
        end
    end

    logic [W-1:0]  mem_q [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] count_q, count_d;
    logic          overrun_q, pop, full, wr_en;
    logic [W-1:0]  head;

    assign pop   = rx_valid && rx_ready;
    assign full  = (count_q == CW'(FIFO_DEPTH));
    assign wr_en = push_q && (!full || pop);

    always_comb begin
        count_d = count_q;
        case ({wr_en, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wr_ptr_q] <= word_q;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            overrun_q <= 1'b0;
        end else begin
            if (wr_en) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop)   rd_ptr_q <= rd_ptr_q + AW'(1);
            count_q   <= count_d;
            overrun_q <= push_q && full && !pop;
        end
    end

    // Head is gated so outputs read 0 while the FIFO is empty (and at reset).
    assign head          = mem_q[rd_ptr_q];
    assign rx_valid      = (count_q != '0);
    assign rx_data       = rx_valid ? head[PAYLOAD_BITS-1:0] : '0;
    assign rx_parity_err = rx_valid ? head[PAYLOAD_BITS] : 1'b0;
    assign rx_frame_err  = rx_valid ? head[PAYLOAD_BITS+1] : 1'b0;
    assign rx_break      = break_q;
    assign rx_overrun    = overrun_q;
    assign fifo_count    = count_q;
endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
Parametrised successor to the team's fixed-format UART receiver.
- Adds a runtime baud divisor, optional parity, 1 or 2 stop bits and 3-sample majority voting.
- Reports framing, parity, break and overrun conditions.
- Buffers received words in a show-ahead FIFO with a valid/ready drain interface.
- Sits between the board RX pin and the RSA datapath's byte loader.

Parameters:
PAYLOAD_BITS, 8, data bits per frame (legal 5..9)
PARITY, 0, 0 = none, 1 = even, 2 = odd
STOP_BITS, 1, stop bits per frame (1 or 2)
DIV_WIDTH, 16, width of the baud divisor
FIFO_DEPTH, 4, word entries (power of 2, at least 2)

Ports:
clk  in  1  system clock
resetn  in  1  asynchronous active-low reset
uart_rxd  in  1  serial line, idle high
uart_rx_en  in  1  receive enable
baud_div  in  DIV_WIDTH  clocks per bit (at least 8); latched on the IDLE to START transition
rx_data  out  PAYLOAD_BITS  FIFO head data
rx_parity_err  out  1  parity error flag of the FIFO head word
rx_frame_err  out  1  frame error flag of the FIFO head word
rx_valid  out  1  FIFO not empty
rx_ready  in  1  consumer pop; a pop occurs when rx_valid && rx_ready
rx_break  out  1  one-cycle pulse on a detected break
rx_overrun  out  1  one-cycle pulse when a word is dropped because the FIFO is full
fifo_count  out  $clog2(FIFO_DEPTH)+1  current occupancy

Behaviour:
- Reset (asynchronous, active-low) values:
  - rx_data, rx_parity_err, rx_frame_err, rx_valid, rx_break, rx_overrun, fifo_count: all 0.
  - Synchroniser flops: 1. FSM: IDLE. FIFO emptied.
- Input synchroniser:
  - uart_rxd passes through a 2-flop synchroniser; rxd_s is the second flop.
  - While uart_rx_en = 0: the synchroniser loads 1, and the FSM returns to IDLE on the next clock, abandoning any partial frame with no push.
  - FIFO contents and the drain interface are unaffected by uart_rx_en.
- Bit timing:
  - cyc counts 0..div-1 within each bit and clears at div-1.
  - div is the value of baud_div latched on entering START.
  - Samples are taken at cyc = h-1, h and h+1, where h = div>>1.
  - The bit value is the majority of the three samples, resolved at cyc = h+1.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE: rxd_s = 0 moves to START with cyc = 0.
  - START: at cyc = h+1, a majority of 1 is a false start and returns to IDLE. Otherwise the state advances to DATA at cyc = div-1.
  - DATA: PAYLOAD_BITS bits, LSB first, shifted in at each resolve.
    - At cyc = div-1 of the last bit, go to PARITY if PARITY != 0, else STOP.
  - PARITY: resolved bit r.
    - parity_err = (^data ^ r) != 0 for even parity.
    - parity_err = (^data ^ r) != 1 for odd parity.
    - Exit to STOP at cyc = div-1.
  - STOP: STOP_BITS bits.
    - frame_err = 1 if any resolved stop bit is 0.
    - At the resolve (cyc = h+1) of the final stop bit, the frame completes and the FSM enters IDLE on the next cycle. It does not wait out the rest of the bit, so it can resync.
- Frame completion:
  - Break: data == 0, the parity bit (if present) == 0, and every stop bit == 0.
    - rx_break pulses 1 cycle; nothing is pushed.
    - The FSM goes to IDLE, then waits in IDLE until rxd_s = 1 before arming a new start.
  - Otherwise the word {frame_err, parity_err, data} is pushed.
    - rx_valid rises on the cycle after the push if the FIFO was empty (1-cycle latency).
- FIFO:
  - Show-ahead: rx_data and the error flags reflect the head entry whenever rx_valid = 1.
  - Push when full with no pop that cycle: the word is dropped, rx_overrun pulses 1 cycle, and the contents are unchanged.
  - Push and pop in the same cycle when full: both take effect and count stays FIFO_DEPTH.
  - Push and pop in the same cycle when empty: only the push takes effect (no pop, since rx_valid = 0).
  - Pointers wrap modulo FIFO_DEPTH; count is kept separately, 0..FIFO_DEPTH.
  - rx_ready is ignored while rx_valid = 0.
- Reset mid-frame: abandons immediately; the next frame needs a fresh falling edge.

Test Plan:
- div = 16, PAYLOAD_BITS = 8, PARITY = 0, STOP_BITS = 1; send 0xA5, rx_ready = 0 -> rx_valid = 1 with rx_data = 0xA5 and both error flags 0; fifo_count = 1.
- PARITY = 1; send 0x07 with parity bit 1 (correct), then 0x07 with parity bit 0 -> two entries with rx_parity_err = 0, then 1.
- 1-cycle low glitch, then a 5-cycle low pulse, at div = 16 -> FSM returns to IDLE; no push and no rx_break.
- Line held low for 12 bit times -> one rx_break pulse and fifo_count stays 0; after the line returns high, 0x3C is received correctly.
- FIFO_DEPTH = 4, rx_ready = 0; send 0x01..0x05 -> the 5th word raises rx_overrun, fifo_count = 4, and the pops return 0x01..0x04 in order. Then with the FIFO full, a push coinciding with a pop keeps fifo_count = 4.
- Stop bit forced to 0 with data 0x81 -> entry 0x81 pushed with rx_frame_err = 1. Separately, resetn asserted mid-DATA -> all outputs 0 asynchronously, and 0x42 sent afterwards is received clean.
